// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller: tracks in-flight instruction tags from ID/EX
// through the last forwarding stage, producing forward selects, load-use stall and counters.
module hazard_forward_unit #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_GAP = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  input  logic                       flush,
  input  logic                       cnt_clr,
  output logic                       stall,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           fwd_cnt
);

  // Stages whose load data is not yet available (indices 0..LOAD_GAP-1).
  localparam logic [NUM_FWD:0] LD_MASK = (NUM_FWD+1)'((64'd1 << LOAD_GAP) - 64'd1);

  // Per-stage tag fields; source fields are only consumed in ID/EX, so only T[0] keeps them.
  logic [NUM_FWD:0]          t_v;
  logic [NUM_FWD:0]          t_wr;
  logic [NUM_FWD:0]          t_ld;
  logic [REG_AW-1:0]         t_rd [0:NUM_FWD];
  logic [NUM_SRC*REG_AW-1:0] t0_rs;
  logic [NUM_SRC-1:0]        t0_used;

  logic [NUM_FWD:0] ld_pend;
  logic             hit;
  logic             issue;
  logic             any_fwd;

  assign ld_pend = t_v & t_wr & t_ld & LD_MASK;

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = 0; k <= NUM_FWD; k++) begin
        if (ld_pend[k] && id_rs_used[i] && (t_rd[k] == id_rs[i*REG_AW +: REG_AW]))
          hit = 1'b1;
      end
    end
  end

  assign stall = id_valid && !flush && hit;
  assign issue = id_valid && !flush && !hit;

  // Scanning from the oldest stage down lets the youngest matching producer win.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      logic [SEL_W-1:0] sel;
      sel = '0;
      for (int unsigned k = NUM_FWD; k >= 1; k--) begin
        if (t_v[k] && t_wr[k] && (t_rd[k] == t0_rs[i*REG_AW +: REG_AW]))
          sel = SEL_W'(k);
      end
      if (t_v[0] && t0_used[i])
        fwd_sel[i*SEL_W +: SEL_W] = sel;
    end
  end

  assign any_fwd = |fwd_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_v     <= '0;
      t_wr    <= '0;
      t_ld    <= '0;
      t0_rs   <= '0;
      t0_used <= '0;
      for (int unsigned k = 0; k <= NUM_FWD; k++)
        t_rd[k] <= '0;
    end else begin
      t_v  <= {t_v[NUM_FWD-1:0], issue};
      t_wr <= {t_wr[NUM_FWD-1:0], id_regwrite && (id_rd != '0)};
      t_ld <= {t_ld[NUM_FWD-1:0], id_memread};
      for (int unsigned k = NUM_FWD; k >= 1; k--)
        t_rd[k] <= t_rd[k-1];
      t_rd[0] <= id_rd;
      t0_rs   <= id_rs;
      t0_used <= id_rs_used;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (any_fwd && (fwd_cnt != '1))
        fwd_cnt <= fwd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: default configuration driven from a vector table, plus a
// hand-written sequence on a NUM_SRC=3 / NUM_FWD=3 / LOAD_GAP=2 / CNT_W=2 instance.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst_a, valid_a, rw_a, mr_a, flush_a, clr_a;
  logic [9:0]  rs_a;
  logic [1:0]  used_a;
  logic [4:0]  rd_a;
  logic        stall_a;
  logic [3:0]  sel_a;
  logic [15:0] scnt_a, fcnt_a;

  hazard_forward_unit dut_a (
    .clk(clk), .rst(rst_a), .id_valid(valid_a), .id_rs(rs_a), .id_rs_used(used_a),
    .id_rd(rd_a), .id_regwrite(rw_a), .id_memread(mr_a), .flush(flush_a),
    .cnt_clr(clr_a), .stall(stall_a), .fwd_sel(sel_a), .stall_cnt(scnt_a), .fwd_cnt(fcnt_a)
  );

  // Wide configuration instance
  logic        rst_b, valid_b, rw_b, mr_b, flush_b, clr_b;
  logic [14:0] rs_b;
  logic [2:0]  used_b;
  logic [4:0]  rd_b;
  logic        stall_b;
  logic [5:0]  sel_b;
  logic [1:0]  scnt_b, fcnt_b;

  hazard_forward_unit #(
    .NUM_SRC(3), .REG_AW(5), .NUM_FWD(3), .LOAD_GAP(2), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .id_valid(valid_b), .id_rs(rs_b), .id_rs_used(used_b),
    .id_rd(rd_b), .id_regwrite(rw_b), .id_memread(mr_b), .flush(flush_b),
    .cnt_clr(clr_b), .stall(stall_b), .fwd_sel(sel_b), .stall_cnt(scnt_b), .fwd_cnt(fcnt_b)
  );

  typedef struct {
    logic        rst, valid;
    logic [4:0]  rs1, rs2;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        rw, mr, flush, clr;
    logic        e_stall;
    logic [3:0]  e_sel;
    logic [15:0] e_scnt, e_fcnt;
  } vec_t;

  vec_t vecs[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  function automatic vec_t mk(logic r, logic v, logic [4:0] s1, logic [4:0] s2, logic [1:0] u,
                              logic [4:0] d, logic w, logic m, logic f, logic c,
                              logic es, logic [3:0] esel, logic [15:0] esc, logic [15:0] efc);
    vec_t t;
    t.rst = r; t.valid = v; t.rs1 = s1; t.rs2 = s2; t.used = u; t.rd = d;
    t.rw = w; t.mr = m; t.flush = f; t.clr = c;
    t.e_stall = es; t.e_sel = esel; t.e_scnt = esc; t.e_fcnt = efc;
    return t;
  endfunction

  task automatic chk(input string name, input int unsigned idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step_b(input int unsigned idx, input logic v, input logic [4:0] r0,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] u,
                        input logic [4:0] d, input logic w, input logic m, input logic c,
                        input logic es, input logic [5:0] esel, input logic [1:0] esc,
                        input logic [1:0] efc);
    valid_b = v; rs_b = {r2, r1, r0}; used_b = u; rd_b = d;
    rw_b = w; mr_b = m; flush_b = 1'b0; clr_b = c; rst_b = 1'b0;
    @(negedge clk);
    vectors++;
    chk("b_stall", idx, 32'(stall_b), 32'(es));
    chk("b_fwd_sel", idx, 32'(sel_b), 32'(esel));
    chk("b_stall_cnt", idx, 32'(scnt_b), 32'(esc));
    chk("b_fwd_cnt", idx, 32'(fcnt_b), 32'(efc));
    @(posedge clk); #1;
  endtask

  initial begin
    // reset, valid, rs1, rs2, used, rd, rw, mr, flush, clr | stall, sel{rs2,rs1}, scnt, fcnt
    vecs.push_back(mk(1,1, 5, 5,3, 5,1,1,0,0, 0,4'h0,0,0)); // 2nd reset cycle, junk inputs
    vecs.push_back(mk(0,1, 1, 2,3, 5,1,0,0,0, 0,4'h0,0,0)); // add x5
    vecs.push_back(mk(0,1, 5, 5,3, 6,1,0,0,0, 0,4'h0,0,0)); // sub x6,x5,x5
    vecs.push_back(mk(0,0, 0, 0,0, 0,0,0,0,0, 0,4'h5,0,0)); // sub in EX: both from stage 1
    vecs.push_back(mk(0,1, 1, 1,3, 7,1,0,0,0, 0,4'h0,0,1)); // add x7
    vecs.push_back(mk(0,0, 0, 0,0, 0,0,0,0,0, 0,4'h0,0,1));
    vecs.push_back(mk(0,0, 0, 0,0, 0,0,0,0,0, 0,4'h0,0,1));
    vecs.push_back(mk(0,1, 7, 7,3, 9,1,0,0,0, 0,4'h0,0,1)); // use x7
    vecs.push_back(mk(0,0, 0, 0,0, 0,0,0,0,0, 0,4'h0,0,1)); // x7 retired: no forward
    vecs.push_back(mk(0,1, 1, 0,1, 3,1,0,0,0, 0,4'h0,0,1)); // write x3 (older)
    vecs.push_back(mk(0,1, 2, 0,1, 3,1,0,0,0, 0,4'h0,0,1)); // write x3 (younger)
    vecs.push_back(mk(0,1, 3, 3,3,10,1,0,0,0, 0,4'h0,0,1)); // read x3
    vecs.push_back(mk(0,1, 3, 3,0,11,1,0,0,0, 0,4'h5,0,1)); // youngest wins; next reads unused
    vecs.push_back(mk(0,0, 0, 0,0, 0,0,0,0,0, 0,4'h0,0,2)); // rs_used=0: no forward
    vecs.push_back(mk(0,1, 2, 0,1, 4,1,1,0,0, 0,4'h0,0,2)); // lw x4
    vecs.push_back(mk(0,1, 4, 1,3, 8,1,0,0,0, 1,4'h0,0,2)); // add x8,x4,x1 stalls
    vecs.push_back(mk(0,1, 4, 1,3, 8,1,0,0,0, 0,4'h0,1,2)); // re-presented, issues
    vecs.push_back(mk(0,0, 0, 0,0, 0,0,0,0,0, 0,4'h2,1,2)); // rs1 from stage 2, rs2 regfile
    vecs.push_back(mk(0,1, 2, 0,1, 4,1,1,0,0, 0,4'h0,1,3)); // lw x4
    vecs.push_back(mk(0,1, 4, 1,3, 8,1,0,1,0, 0,4'h0,1,3)); // hit + flush: no stall
    vecs.push_back(mk(0,0, 0, 0,0, 0,0,0,0,0, 0,4'h0,1,3)); // bubble in EX, stall_cnt held
    vecs.push_back(mk(0,1, 2, 0,1, 4,1,1,0,0, 0,4'h0,1,3)); // lw x4
    vecs.push_back(mk(0,0, 4, 0,1, 0,0,0,0,0, 0,4'h0,1,3)); // invalid ID with matching rs
    vecs.push_back(mk(0,1, 1, 0,1, 0,1,1,0,0, 0,4'h0,1,3)); // load to x0
    vecs.push_back(mk(0,1, 0, 0,3,12,1,0,0,0, 0,4'h0,1,3)); // read x0: no stall
    vecs.push_back(mk(0,0, 0, 0,0, 0,0,0,0,0, 0,4'h0,1,3)); // and no forward from x0
    vecs.push_back(mk(0,1, 2, 0,1, 4,1,1,0,0, 0,4'h0,1,3)); // lw x4
    vecs.push_back(mk(1,1, 4, 1,3, 8,1,0,0,0, 1,4'h0,1,3)); // reset during stall
    vecs.push_back(mk(0,1, 4, 1,3, 8,1,0,0,0, 0,4'h0,0,0)); // stall gone, counters cleared
    vecs.push_back(mk(0,0, 0, 0,0, 0,0,0,0,0, 0,4'h0,0,0));

    // Hold the wide instance in reset while the table runs
    rst_b = 1'b1; valid_b = 1'b0; rs_b = '0; used_b = '0; rd_b = '0;
    rw_b = 1'b0; mr_b = 1'b0; flush_b = 1'b0; clr_b = 1'b0;

    // First reset cycle with random ID inputs (state unknown before this edge)
    rst_a = 1'b1; valid_a = 1'b1; rs_a = 10'($urandom); used_a = 2'($urandom);
    rd_a = 5'($urandom); rw_a = 1'b1; mr_a = 1'b1; flush_a = 1'b0; clr_a = 1'b0;
    @(posedge clk); #1;

    for (int unsigned n = 0; n < vecs.size(); n++) begin
      rst_a = vecs[n].rst; valid_a = vecs[n].valid; rs_a = {vecs[n].rs2, vecs[n].rs1};
      used_a = vecs[n].used; rd_a = vecs[n].rd; rw_a = vecs[n].rw; mr_a = vecs[n].mr;
      flush_a = vecs[n].flush; clr_a = vecs[n].clr;
      @(negedge clk);
      vectors++;
      chk("a_stall", n, 32'(stall_a), 32'(vecs[n].e_stall));
      chk("a_fwd_sel", n, 32'(sel_a), 32'(vecs[n].e_sel));
      chk("a_stall_cnt", n, 32'(scnt_a), 32'(vecs[n].e_scnt));
      chk("a_fwd_cnt", n, 32'(fcnt_a), 32'(vecs[n].e_fcnt));
      @(posedge clk); #1;
    end

    // Wide instance: LOAD_GAP=2 gives two stall cycles, forward from stage 3, CNT_W=2 saturates
    //      idx v  rs0 rs1 rs2 used   rd  rw mr clr | stall sel        scnt fcnt
    step_b( 0, 1,  2,  0,  0, 3'b001, 4, 1, 1, 0,   0, 6'b000000, 0, 0); // lw x4
    step_b( 1, 1,  4,  1,  4, 3'b111, 8, 1, 0, 0,   1, 6'b000000, 0, 0);
    step_b( 2, 1,  4,  1,  4, 3'b111, 8, 1, 0, 0,   1, 6'b000000, 1, 0);
    step_b( 3, 1,  4,  1,  4, 3'b111, 8, 1, 0, 0,   0, 6'b000000, 2, 0);
    step_b( 4, 0,  0,  0,  0, 3'b000, 0, 0, 0, 0,   0, 6'b110011, 2, 0); // rs0,rs2 from stage 3
    step_b( 5, 1,  1,  0,  0, 3'b001, 9, 1, 1, 0,   0, 6'b000000, 2, 1); // lw x9
    step_b( 6, 1,  9,  9,  9, 3'b111,10, 1, 0, 0,   1, 6'b000000, 2, 1);
    step_b( 7, 1,  9,  9,  9, 3'b111,10, 1, 0, 0,   1, 6'b000000, 3, 1);
    step_b( 8, 1,  9,  9,  9, 3'b111,10, 1, 0, 0,   0, 6'b000000, 3, 1); // saturated
    step_b( 9, 1,  1,  0,  0, 3'b001, 9, 1, 1, 0,   0, 6'b111111, 3, 1); // lw x9 again
    step_b(10, 1,  9,  9,  9, 3'b111,10, 1, 0, 0,   1, 6'b000000, 3, 2);
    step_b(11, 1,  9,  9,  9, 3'b111,10, 1, 0, 1,   1, 6'b000000, 3, 2); // clear beats increment
    step_b(12, 1,  9,  9,  9, 3'b111,10, 1, 0, 0,   0, 6'b000000, 0, 0);
    step_b(13, 0,  0,  0,  0, 3'b000, 0, 0, 0, 0,   0, 6'b111111, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding controller for the pipelined RISC-V core; it replaces the purely combinational EX-stage forwarding compare. It keeps its own pipeline of in-flight instruction tags from ID/EX through the last forwarding stage, so the datapath only presents the instruction currently in ID. From that history it produces per-source forward selects for the instruction in EX, a load-use stall for ID, and saturating performance counters. Source-port count, register address width, forwarding depth and load latency are all parameters.

## Interface
- NUM_SRC, 2: source operands per instruction (rs1, rs2, …)
- REG_AW, 5: register address width
- NUM_FWD, 2: forwarding stages after EX. Stage 1 is EX/MEM, stage 2 is MEM/WB, and so on.
- LOAD_GAP, 1: number of stages, counted from ID/EX, in which load data is not yet available. Legal range is 0 ≤ LOAD_GAP < NUM_FWD.
- CNT_W, 16: width of each performance counter
- SEL_W: derived as $clog2(NUM_FWD+1); not overridable
- clk  in  1  clock. Everything is registered on the rising edge.
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NUM_SRC*REG_AW  ID source registers; source i is at bits [i*REG_AW +: REG_AW]
- id_rs_used  in  NUM_SRC  bit i set when source i is actually read
- id_rd  in  REG_AW  ID destination register
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- flush  in  1  squash the ID instruction (taken branch or jump)
- cnt_clr  in  1  clear both counters
- stall  out  1  hold PC and IF/ID, insert a bubble into ID/EX. Combinational.
- fwd_sel  out  NUM_SRC*SEL_W  per source of the EX instruction. 0 selects the register file; k selects stage k. Combinational.
- stall_cnt  out  CNT_W  cycles with stall=1. Registered, saturating.
- fwd_cnt  out  CNT_W  cycles where the EX instruction forwarded at least one source. Registered, saturating.

## Operation
- Tag array T[0..NUM_FWD], where T[0] is the ID/EX stage. Each tag holds:
  - v
  - rs[NUM_SRC], used[NUM_SRC]
  - rd
  - wr = regwrite && rd≠0, so x0 never matches
  - ld (load flag)
- Hazard hit: for some i and some k < LOAD_GAP, T[k].v && T[k].ld && T[k].wr && T[k].rd == id_rs[i] && id_rs_used[i].
- stall = id_valid && !flush && hit.
- fwd_sel[i]: the smallest k in 1..NUM_FWD with T[k].v && T[k].wr && T[k].rd == T[0].rs[i], provided T[0].v && T[0].used[i]. Otherwise 0. The youngest producer wins.
- The stall rule guarantees that any load producer selected sits at k ≥ LOAD_GAP+1.
- Update on every clock edge:
  - T[k] ← T[k-1] for k = 1..NUM_FWD; T[NUM_FWD] retires.
  - T[0] ← bubble (v=0) if flush, stall or !id_valid.
  - Otherwise T[0] ← ID fields with v=1.
- Counters:
  - stall_cnt increments when stall=1.
  - fwd_cnt increments when any fwd_sel ≠ 0.
  - Both saturate at 2^CNT_W−1.
  - cnt_clr takes priority over an increment in the same cycle.

## Timing
- Reset, or any rst=1 mid-stream: all T[k].v ← 0 and both counters ← 0 at the next edge. The following cycle stall=0 and fwd_sel=0 unless ID inputs cause a hit. T[k] is empty, so no hit is possible.
- stall and fwd_sel have zero latency: combinational from state and ID inputs. Counters reflect the previous cycle.
- Load-use with LOAD_GAP=1:
  - Exactly one stall cycle.
  - Next cycle the load sits at T[1] and the re-presented instruction issues.
  - One cycle later the consumer is at T[0], the load at T[2], and fwd_sel=2.
- flush and hit together: stall=0, bubble inserted, and stall_cnt does not increment.
- id_valid=0 with matching fields: no stall.
- Producer and consumer both using rd=x0: no forward and no stall.

## Test plan
- Reset: assert rst 2 cycles with random ID inputs → stall=0, fwd_sel=0, counters=0. Reset mid-stall → stall drops after the edge.
- Back-to-back: issue add x5 then sub x6,x5,x5 → the cycle sub is in EX, fwd_sel={2'd1,2'd1}. add x7 then two NOPs then use x7 → fwd_sel=0, because x7 has retired past NUM_FWD.
- Priority: write x3 twice, then read x3 → fwd_sel=1 (youngest). Read x3 with rs_used=0 → fwd_sel=0.
- Load-use: lw x4 then add x8,x4,x1 → stall=1 for 1 cycle, stall_cnt=1, then the add's rs1 sel=2 and rs2 sel=0.
- Flush during hit: the load-use pair with flush=1 on the stall cycle → stall=0 and T[0] is a bubble, so the next cycle has fwd_sel=0.
- Parameters: NUM_SRC=3, NUM_FWD=3, LOAD_GAP=2, CNT_W=2 → a load followed by a dependent instruction stalls 2 cycles and then forwards from stage 3. Four or more stalls saturate stall_cnt at 3. cnt_clr together with stall → 0.
